// File: rtl/fp_int_frac_split.sv
// fp_int_frac_split: splits a float into floor(|x|) as unsigned binary and |x|-floor(|x|) as a float with x's sign.
// Latency: 3 cycles from accept to out_valid, one result per cycle, order preserved.
// Backpressure: every stage holds while out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Optional macro INT_SAT_EN: int_o saturates when e >= INT_W and the ovf_o port is added.
// Assumes INT_W >= MAN_W+1 so that the integer part of any e < MAN_W fits in int_o.
module fp_int_frac_split #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     ip,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INT_W-1:0]         int_o,
    output logic [EXP_W+MAN_W:0]     fracfp,
    output logic                     sign_o,
`ifdef INT_SAT_EN
    output logic                     ovf_o,
`endif
    output logic                     exc_o
);

    localparam int FP_W = EXP_W + MAN_W + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);
    localparam logic signed [EXP_W:0] MAN_S  = (EXP_W+1)'(MAN_W);
`ifdef INT_SAT_EN
    localparam logic signed [EXP_W:0] INT_S  = (EXP_W+1)'(INT_W);
`endif

    // Index of the most significant set bit; 0 when the vector is empty.
    function automatic logic [EXP_W:0] lead_one(input logic [MAN_W-1:0] f);
        lead_one = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (f[i]) lead_one = (EXP_W+1)'(i);
        end
    endfunction

    logic                   w_adv;
    logic [EXP_W-1:0]       w1_exp;
    logic signed [EXP_W:0]  w1_e;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w1_exp   = ip[FP_W-2:MAN_W];
    assign w1_e     = $signed({1'b0, w1_exp}) - BIAS_S;

    // Stage 1 registers: unpacked operand.
    logic                   r1_vld;
    logic [FP_W-1:0]        r1_ip;
    logic signed [EXP_W:0]  r1_e;
    logic [MAN_W:0]         r1_m;
    logic                   r1_zero;
    logic                   r1_exc;

    // Stage 1: capture the accepted operand and unpack exponent and mantissa
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld  <= 1'b0;
            r1_ip   <= '0;
            r1_e    <= '0;
            r1_m    <= '0;
            r1_zero <= 1'b0;
            r1_exc  <= 1'b0;
        end else if (w_adv) begin
            r1_vld  <= in_valid;
            r1_ip   <= ip;
            r1_e    <= w1_e;
            r1_m    <= {1'b1, ip[MAN_W-1:0]};
            r1_zero <= (w1_exp == '0);
            r1_exc  <= (w1_exp == '1);
        end
    end

    logic [INT_W-1:0]       w1_m_ext;
    logic [EXP_W:0]         w2_rsh;
    logic [EXP_W:0]         w2_lsh;
    logic [INT_W-1:0]       w2_int;
    logic [FP_W-1:0]        w2_frac;
    logic [MAN_W-1:0]       w2_f;
    logic                   w2_norm;
`ifdef INT_SAT_EN
    logic                   w2_ovf;
`endif

    assign w1_m_ext = INT_W'(r1_m);
    assign w2_rsh   = MAN_S - r1_e;
    assign w2_lsh   = r1_e - MAN_S;

    // Stage 2: classify the operand and split it with the barrel shifters
    always_comb begin
        w2_int  = '0;
        w2_frac = {r1_ip[FP_W-1], {(FP_W-1){1'b0}}};
        w2_f    = '0;
        w2_norm = 1'b0;
`ifdef INT_SAT_EN
        w2_ovf  = 1'b0;
`endif
        if (r1_exc) begin
            w2_frac = r1_ip;                      // Inf/NaN passes through
        end else if (r1_zero) begin
            w2_frac = {r1_ip[FP_W-1], {(FP_W-1){1'b0}}};  // zero and flushed denormals
        end else if (r1_e[EXP_W]) begin
            w2_frac = r1_ip;                      // |x| < 1: all fraction
        end else if (r1_e < MAN_S) begin
            w2_int  = w1_m_ext >> w2_rsh;
            w2_f    = r1_m[MAN_W-1:0] & ~({MAN_W{1'b1}} << w2_rsh);
            w2_norm = 1'b1;
        end else begin
            w2_int  = w1_m_ext << w2_lsh;         // no fraction bits remain
`ifdef INT_SAT_EN
            if (r1_e >= INT_S) begin
                w2_int = '1;
                w2_ovf = 1'b1;
            end
`endif
        end
    end

    // Stage 2 registers: split results awaiting normalisation.
    logic                   r2_vld;
    logic                   r2_sign;
    logic                   r2_exc;
    logic [INT_W-1:0]       r2_int;
    logic [FP_W-1:0]        r2_frac;
    logic [MAN_W-1:0]       r2_f;
    logic [EXP_W:0]         r2_sh;
    logic                   r2_norm;
`ifdef INT_SAT_EN
    logic                   r2_ovf;
`endif

    // Stage 2: register the integer part and the raw fraction bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_vld  <= 1'b0;
            r2_sign <= 1'b0;
            r2_exc  <= 1'b0;
            r2_int  <= '0;
            r2_frac <= '0;
            r2_f    <= '0;
            r2_sh   <= '0;
            r2_norm <= 1'b0;
`ifdef INT_SAT_EN
            r2_ovf  <= 1'b0;
`endif
        end else if (w_adv) begin
            r2_vld  <= r1_vld;
            r2_sign <= r1_ip[FP_W-1];
            r2_exc  <= r1_exc;
            r2_int  <= w2_int;
            r2_frac <= w2_frac;
            r2_f    <= w2_f;
            r2_sh   <= w2_rsh;
            r2_norm <= w2_norm;
`ifdef INT_SAT_EN
            r2_ovf  <= w2_ovf;
`endif
        end
    end

    logic [EXP_W:0]         w3_p;
    logic [EXP_W-1:0]       w3_exp;
    logic [MAN_W-1:0]       w3_man;
    logic [FP_W-1:0]        w3_frac;

    // Stage 3: renormalise the fraction bits; truncation only, no rounding
    always_comb begin
        w3_p    = lead_one(r2_f);
        w3_exp  = EXP_W'(BIAS_S - r2_sh + w3_p);
        w3_man  = r2_f << ((EXP_W+1)'(MAN_W) - w3_p);
        w3_frac = r2_frac;
        if (r2_norm) begin
            if (r2_f == '0) w3_frac = {r2_sign, {(FP_W-1){1'b0}}};
            else            w3_frac = {r2_sign, w3_exp, w3_man};
        end
    end

    // Output registers: held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            int_o     <= '0;
            fracfp    <= '0;
            sign_o    <= 1'b0;
            exc_o     <= 1'b0;
`ifdef INT_SAT_EN
            ovf_o     <= 1'b0;
`endif
        end else if (w_adv) begin
            out_valid <= r2_vld;
            int_o     <= r2_int;
            fracfp    <= w3_frac;
            sign_o    <= r2_sign;
            exc_o     <= r2_exc;
`ifdef INT_SAT_EN
            ovf_o     <= r2_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_fp_int_frac_split.sv
// tb_fp_int_frac_split: directed vectors with hand-computed results for fp_int_frac_split.
// Latency: checks the 3-cycle accept-to-result timing on every single-shot vector.
// Backpressure: exercises a 5-cycle output stall on a 6-deep stream and a mid-flight reset.
`timescale 1ns/1ps
module tb_fp_int_frac_split;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] ip        = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] int_o;
    logic [31:0] fracfp;
    logic        sign_o;
    logic        exc_o;
    logic        ovf_w;

    int checks   = 0;
    int failures = 0;

`ifdef INT_SAT_EN
    logic ovf_o;
    assign ovf_w = ovf_o;
`else
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_int_frac_split #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ip        (ip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .int_o     (int_o),
        .fracfp    (fracfp),
        .sign_o    (sign_o),
`ifdef INT_SAT_EN
        .ovf_o     (ovf_o),
`endif
        .exc_o     (exc_o)
    );

    // Presents one operand with out_ready high, returns out_valid two and three edges after accept.
    task automatic send_one(input logic [31:0] x, output logic v2, output logic v3,
                            output logic [31:0] oi, output logic [31:0] of,
                            output logic os, output logic oe, output logic oo);
        @(posedge clk); #1;
        out_ready = 1'b1; ip = x; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ip = '0;
        @(posedge clk); #1;
        v2 = out_valid;
        @(posedge clk); #1;
        v3 = out_valid; oi = int_o; of = fracfp; os = sign_o; oe = exc_o; oo = ovf_w;
    endtask

    task automatic test_reset();
        out_ready = 1'b0; in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (int_o !== 32'h0)     begin failures++; $display("FAIL rst_int_o got=%h exp=0", int_o); end
        checks++; if (fracfp !== 32'h0)    begin failures++; $display("FAIL rst_fracfp got=%h exp=0", fracfp); end
        checks++; if (sign_o !== 1'b0)     begin failures++; $display("FAIL rst_sign_o got=%b exp=0", sign_o); end
        checks++; if (exc_o !== 1'b0)      begin failures++; $display("FAIL rst_exc_o got=%b exp=0", exc_o); end
        checks++; if (ovf_w !== 1'b0)      begin failures++; $display("FAIL rst_ovf_o got=%b exp=0", ovf_w); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_frac_split();
        logic [31:0] vin [4];
        logic [31:0] eint [4];
        logic [31:0] efrac [4];
        logic        esgn [4];
        logic        v2, v3, s, e, o;
        logic [31:0] oi, of;
        vin   = '{32'h4124CCCD, 32'hC0600000, 32'h3F400000, 32'hBF400000};
        eint  = '{32'd10, 32'd3, 32'd0, 32'd0};
        efrac = '{32'h3E9999A0, 32'hBF000000, 32'h3F400000, 32'hBF400000};
        esgn  = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_one(vin[i], v2, v3, oi, of, s, e, o);
            checks++; if (v2 !== 1'b0)     begin failures++; $display("FAIL frac_early_valid ip=%h got=%b exp=0", vin[i], v2); end
            checks++; if (v3 !== 1'b1)     begin failures++; $display("FAIL frac_latency ip=%h got=%b exp=1", vin[i], v3); end
            checks++; if (oi !== eint[i])  begin failures++; $display("FAIL frac_int ip=%h got=%h exp=%h", vin[i], oi, eint[i]); end
            checks++; if (of !== efrac[i]) begin failures++; $display("FAIL frac_fracfp ip=%h got=%h exp=%h", vin[i], of, efrac[i]); end
            checks++; if (s !== esgn[i])   begin failures++; $display("FAIL frac_sign ip=%h got=%b exp=%b", vin[i], s, esgn[i]); end
            checks++; if (e !== 1'b0 || o !== 1'b0) begin failures++; $display("FAIL frac_flags ip=%h got=%b%b exp=00", vin[i], e, o); end
        end
    endtask

    task automatic test_large_int();
        logic [31:0] vin [4];
        logic [31:0] eint [4];
        logic        eovf [4];
        logic        v2, v3, s, e, o;
        logic [31:0] oi, of;
        vin  = '{32'h4B800000, 32'h4F000000, 32'h4F800000, 32'h53800000};
`ifdef INT_SAT_EN
        eint = '{32'h01000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        eovf = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        eint = '{32'h01000000, 32'h80000000, 32'h00000000, 32'h00000000};
        eovf = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            send_one(vin[i], v2, v3, oi, of, s, e, o);
            checks++; if (v3 !== 1'b1)    begin failures++; $display("FAIL big_latency ip=%h got=%b exp=1", vin[i], v3); end
            checks++; if (oi !== eint[i]) begin failures++; $display("FAIL big_int ip=%h got=%h exp=%h", vin[i], oi, eint[i]); end
            checks++; if (of !== 32'h0)   begin failures++; $display("FAIL big_fracfp ip=%h got=%h exp=0", vin[i], of); end
            checks++; if (o !== eovf[i])  begin failures++; $display("FAIL big_ovf ip=%h got=%b exp=%b", vin[i], o, eovf[i]); end
        end
    endtask

    task automatic test_special();
        logic [31:0] vin [4];
        logic [31:0] efrac [4];
        logic        eexc [4];
        logic        esgn [4];
        logic        v2, v3, s, e, o;
        logic [31:0] oi, of;
        vin   = '{32'h7FC00000, 32'h00000001, 32'hFF800000, 32'h80000000};
        efrac = '{32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h80000000};
        eexc  = '{1'b1, 1'b0, 1'b1, 1'b0};
        esgn  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_one(vin[i], v2, v3, oi, of, s, e, o);
            checks++; if (v3 !== 1'b1)     begin failures++; $display("FAIL spc_latency ip=%h got=%b exp=1", vin[i], v3); end
            checks++; if (e !== eexc[i])   begin failures++; $display("FAIL spc_exc ip=%h got=%b exp=%b", vin[i], e, eexc[i]); end
            checks++; if (oi !== 32'h0)    begin failures++; $display("FAIL spc_int ip=%h got=%h exp=0", vin[i], oi); end
            checks++; if (of !== efrac[i]) begin failures++; $display("FAIL spc_fracfp ip=%h got=%h exp=%h", vin[i], of, efrac[i]); end
            checks++; if (s !== esgn[i])   begin failures++; $display("FAIL spc_sign ip=%h got=%b exp=%b", vin[i], s, esgn[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin [6];
        logic [31:0] eint [6];
        logic [31:0] efrac [6];
        logic [31:0] gint [6];
        logic [31:0] gfrac [6];
        int          ngot;
        vin   = '{32'h4124CCCD, 32'hC0600000, 32'h3F400000, 32'h4B800000, 32'h3F800000, 32'h40200000};
        eint  = '{32'd10, 32'd3, 32'd0, 32'h01000000, 32'd1, 32'd2};
        efrac = '{32'h3E9999A0, 32'hBF000000, 32'h3F400000, 32'h0, 32'h0, 32'h3F000000};
        ngot  = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin : driver
                int idx = 0;
                int guard = 0;
                logic hs;
                while (idx < 6 && guard < 200) begin
                    ip = vin[idx]; in_valid = 1'b1;
                    @(negedge clk);
                    hs = in_ready;
                    @(posedge clk); #1;
                    if (hs) idx++;
                    guard++;
                end
                in_valid = 1'b0; ip = '0;
                checks++; if (idx != 6) begin failures++; $display("FAIL b2b_sent got=%0d exp=6", idx); end
            end
            begin : monitor
                int cyc = 0;
                @(negedge clk);
                while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
                        begin failures++; $display("FAIL b2b_stall cyc=%0d got=rdy%b vld%b exp=rdy0 vld1", k, in_ready, out_valid); end
                    checks++; if (int_o !== eint[0] || fracfp !== efrac[0])
                        begin failures++; $display("FAIL b2b_hold cyc=%0d got=%h/%h exp=%h/%h", k, int_o, fracfp, eint[0], efrac[0]); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                cyc = 0;
                while (ngot < 6 && cyc < 100) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        gint[ngot] = int_o; gfrac[ngot] = fracfp; ngot++;
                    end
                    cyc++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (out_valid) ngot++;
                end
            end
        join
        checks++; if (ngot != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", ngot); end
        for (int i = 0; i < 6 && i < ngot; i++) begin
            checks++; if (gint[i] !== eint[i] || gfrac[i] !== efrac[i])
                begin failures++; $display("FAIL b2b_order idx=%0d got=%h/%h exp=%h/%h", i, gint[i], gfrac[i], eint[i], efrac[i]); end
        end
    endtask

    task automatic test_reset_inflight();
        logic stale;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; ip = 32'hC0600000;
        @(posedge clk); #1 ip = 32'h4124CCCD;
        @(posedge clk); #1 ip = 32'h3F400000;
        @(posedge clk); #1 in_valid = 1'b0; ip = '0;
        checks++; if (out_valid !== 1'b1 || int_o !== 32'd3 || sign_o !== 1'b1)
            begin failures++; $display("FAIL rif_pre got=vld%b int%h sgn%b exp=vld1 int00000003 sgn1", out_valid, int_o, sign_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_out_valid got=%b exp=0", out_valid); end
        checks++; if (int_o !== 32'h0 || fracfp !== 32'h0 || sign_o !== 1'b0 || exc_o !== 1'b0)
            begin failures++; $display("FAIL rif_outputs got=%h/%h/%b/%b exp=0/0/0/0", int_o, fracfp, sign_o, exc_o); end
        @(posedge clk); #1 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rif_stale got=%b exp=0", stale); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rif_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_frac_split();
        test_large_int();
        test_special();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
